i2s_rx: RTL and testbench

- Front-end deserializer for the equalizer datapath.
- Receives a standard I2S stereo stream (BCLK/LRCK/SDATA from the ADC/codec) oversampled in the i_clk domain.
- Emits one 24-bit signed left/right sample pair per audio frame, with a single-cycle o_valid strobe that drives the filter bank's i_en/i_data inputs directly.

---
 rtl/i2s_rx_if.sv | 27 ++
 rtl/i2s_rx.sv | 172 +++++++++++++++++
 tb/tb_i2s_rx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// I2S receiver bundle: raw asynchronous I2S inputs plus the decoded sample-pair outputs.
// Latency: none; this file only groups wires.
// Backpressure: none; the stream is free-running, so o_valid/o_err are strobes with no ready.
`timescale 1ns/1ps
interface i2s_rx_if #(
  parameter int DW = 24
);
  logic                 i_bclk;
  logic                 i_lrck;
  logic                 i_sdata;
  logic signed [DW-1:0] o_left;
  logic signed [DW-1:0] o_right;
  logic                 o_valid;
  logic                 o_err;

  // Stream/codec side: drives the serial lines and observes the decoded pair.
  modport master (
    output i_bclk, i_lrck, i_sdata,
    input  o_left, o_right, o_valid, o_err
  );

  // Receiver side.
  modport slave (
    input  i_bclk, i_lrck, i_sdata,
    output o_left, o_right, o_valid, o_err
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S stereo deserializer: oversamples BCLK/LRCK/SDATA in i_clk and emits one signed DW-bit L/R pair per frame.
// Latency: o_valid rises SYNC_STAGES+2 i_clk edges after the raw BCLK rise of the right word's last bit is registered.
// Backpressure: none; o_valid/o_err are single-cycle strobes and o_left/o_right hold until the next pair.
`timescale 1ns/1ps
module i2s_rx #(
  parameter int DW          = 24,
  parameter int SYNC_STAGES = 2
) (
  input logic     i_clk,
  input logic     i_rst_n,
  i2s_rx_if.slave bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_sdata_sync;
  logic                   r_bclk_prev, r_rise, r_lrck_smp, r_sdata_smp;
  logic                   r_lrck_last, r_have_lr;
  logic                   w_bclk, w_rise, w_lr_chg;

  state_t                 r_state, w_state_nxt;
  logic [DW-1:0]          r_shift, w_shift_nxt;
  logic [CW-1:0]          r_bit_cnt, w_cnt_nxt, w_cnt_inc;
  logic                   r_slot_lr, w_slot_lr_nxt;
  logic                   r_done, w_done_nxt, r_done_lr;
  logic                   r_err, w_err_nxt;

  logic [DW-1:0]          r_hold, r_left, r_right;
  logic                   r_left_ok, r_valid, r_err_o;

  assign w_bclk    = r_bclk_sync[SYNC_STAGES-1];
  assign w_rise    = w_bclk & ~r_bclk_prev;
  // The very first sampled LRCK after reset only seeds the history; it can never
  // look like a slot boundary, so capture never begins mid-word.
  assign w_lr_chg  = r_rise & r_have_lr & (r_lrck_smp != r_lrck_last);
  assign w_cnt_inc = r_bit_cnt + CW'(1);

  // Synchronize the async inputs, detect BCLK rise, sample LRCK/SDATA on it and keep LRCK history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bclk_sync  <= '0;
      r_lrck_sync  <= '0;
      r_sdata_sync <= '0;
      r_bclk_prev  <= 1'b0;
      r_rise       <= 1'b0;
      r_lrck_smp   <= 1'b0;
      r_sdata_smp  <= 1'b0;
      r_lrck_last  <= 1'b0;
      r_have_lr    <= 1'b0;
    end else begin
      r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], bus.i_bclk};
      r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], bus.i_lrck};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], bus.i_sdata};
      r_bclk_prev  <= w_bclk;
      r_rise       <= w_rise;
      if (w_rise) begin
        r_lrck_smp  <= r_lrck_sync[SYNC_STAGES-1];
        r_sdata_smp <= r_sdata_sync[SYNC_STAGES-1];
      end
      if (r_rise) begin
        r_lrck_last <= r_lrck_smp;
        r_have_lr   <= 1'b1;
      end
    end
  end

  // Slot FSM state register; r_done_lr trails r_slot_lr so the commit stage sees the finished word's channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_slot_lr <= 1'b0;
      r_done    <= 1'b0;
      r_done_lr <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_slot_lr <= w_slot_lr_nxt;
      r_done    <= w_done_nxt;
      r_done_lr <= r_slot_lr;
      r_err     <= w_err_nxt;
    end
  end

  // Slot FSM next state. The rise that reveals the LRCK change carries the one-bit
  // delay (previous word's LSB), so DELAY waits for the MSB on the following rise.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_bit_cnt;
    w_slot_lr_nxt = r_slot_lr;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_lr_chg) begin
          w_state_nxt   = S_DELAY;
          w_slot_lr_nxt = r_lrck_smp;
          w_cnt_nxt     = '0;
        end
      end
      S_DELAY: begin
        if (r_rise) begin
          w_shift_nxt = {r_shift[DW-2:0], r_sdata_smp};
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_rise) begin
          w_shift_nxt = {r_shift[DW-2:0], r_sdata_smp};
          w_cnt_nxt   = w_cnt_inc;
          if (w_cnt_inc == CW'(DW)) begin
            // Completion wins over a coincident LRCK change; that change then opens the next slot.
            w_done_nxt = 1'b1;
            if (w_lr_chg) begin
              w_state_nxt   = S_DELAY;
              w_slot_lr_nxt = r_lrck_smp;
              w_cnt_nxt     = '0;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else if (w_lr_chg) begin
            w_err_nxt     = 1'b1;
            w_state_nxt   = S_DELAY;
            w_slot_lr_nxt = r_lrck_smp;
            w_cnt_nxt     = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Commit finished words: left waits in r_hold, a right word publishes the pair only if a good left preceded it.
  // r_shift is stable here since BCLK rises are at least four i_clk cycles apart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold    <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_left_ok <= 1'b0;
      r_valid   <= 1'b0;
      r_err_o   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err_o <= r_err;
      if (r_err) begin
        r_left_ok <= 1'b0;
      end else if (r_done) begin
        if (!r_done_lr) begin
          r_hold    <= r_shift;
          r_left_ok <= 1'b1;
        end else if (r_left_ok) begin
          r_left    <= r_hold;
          r_right   <= r_shift;
          r_valid   <= 1'b1;
          r_left_ok <= 1'b0;
        end
      end
    end
  end

  assign bus.o_left  = r_left;
  assign bus.o_right = r_right;
  assign bus.o_valid = r_valid;
  assign bus.o_err   = r_err_o;
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: I2S frames of varied slot sizes, short slot, resets mid-word, right-first start.
// Latency: checks o_valid lands SYNC_STAGES+2 edges after the registered raw BCLK rise of the right LSB.
// Backpressure: none; the bench counts o_valid/o_err strobes and checks held outputs.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int DW = 24;
  // Marker taken at the negedge before edge E0, so E0+SYNC_STAGES+2 is read back as a difference of 2+3.
  localparam int EXP_LAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  i2s_rx_if #(.DW(DW)) bus();

  i2s_rx #(.DW(DW), .SYNC_STAGES(2)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mark_cyc = 0;
  int lat = -1;
  int vld_cnt = 0;
  int err_cnt = 0;
  int pw_bad = 0;
  logic prev_vld = 1'b0;
  logic prev_err = 1'b0;
  logic carry = 1'b0;
  logic carry_mark = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts pulses, measures latency, flags any strobe wider than one cycle.
  always @(negedge clk) begin
    if (bus.o_valid) begin
      vld_cnt = vld_cnt + 1;
      lat = cyc - mark_cyc;
      if (prev_vld) pw_bad = pw_bad + 1;
    end
    if (bus.o_err) begin
      err_cnt = err_cnt + 1;
      if (prev_err) pw_bad = pw_bad + 1;
    end
    prev_vld = bus.o_valid;
    prev_err = bus.o_err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One BCLK period (8 i_clk): data/LRCK change with the falling BCLK, sampled on the rise.
  task automatic send_bit(input logic lr, input logic d, input logic mk);
    @(negedge clk);
    bus.i_bclk  = 1'b0;
    bus.i_lrck  = lr;
    bus.i_sdata = d;
    repeat (4) @(negedge clk);
    bus.i_bclk = 1'b1;
    if (mk) mark_cyc = cyc;
    repeat (3) @(negedge clk);
  endtask

  // One LRCK slot of nbits. Rise 0 carries the previous word's LSB; rises 1..DW carry this word MSB-first.
  task automatic send_slot(input logic lr, input logic [DW-1:0] word, input int nbits);
    logic d, mk;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0) begin
        d  = carry;
        mk = carry_mark;
      end else if (k <= DW) begin
        d  = word[DW-k];
        mk = lr && (k == DW);
      end else begin
        d  = 1'b0;
        mk = 1'b0;
      end
      send_bit(lr, d, mk);
    end
    if (nbits <= DW) begin
      carry      = word[DW-nbits];
      carry_mark = lr && (nbits == DW);
    end else begin
      carry      = 1'b0;
      carry_mark = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nbits);
    send_slot(1'b0, l, nbits);
    send_slot(1'b1, r, nbits);
  endtask

  int v0, e0;

  initial begin
    bus.i_bclk  = 1'b0;
    bus.i_lrck  = 1'b1;
    bus.i_sdata = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_left",  {8'h0, bus.o_left},  32'h0);
    check("rst_right", {8'h0, bus.o_right}, 32'h0);
    check("rst_valid", {31'h0, bus.o_valid}, 32'h0);
    check("rst_err",   {31'h0, bus.o_err},   32'h0);
    rst_n = 1'b1;

    // 32-bit slots, four identical frames.
    send_slot(1'b1, 24'h0, 32);
    v0 = vld_cnt; e0 = err_cnt;
    for (int f = 0; f < 4; f++) begin
      send_frame(24'h123456, 24'hABCDEF, 32);
      check("g1_vld_cnt", vld_cnt, v0 + f + 1);
      check("g1_left",  {8'h0, bus.o_left},  32'h123456);
      check("g1_right", {8'h0, bus.o_right}, 32'hABCDEF);
      check("g1_latency", lat, EXP_LAT);
    end
    check("g1_err_cnt", err_cnt, e0);

    // 24-bit slots: right LSB lands on the next left slot's first rise.
    v0 = vld_cnt;
    send_frame(24'h800000, 24'h7FFFFF, 24);
    send_frame(24'h800000, 24'h7FFFFF, 24);
    send_slot(1'b0, 24'h0F0F0F, 32);
    check("g2_vld_cnt", vld_cnt, v0 + 2);
    check("g2_left_neg",  int'(bus.o_left),  -8388608);
    check("g2_right_pos", int'(bus.o_right), 8388607);
    check("g2_latency", lat, EXP_LAT);
    send_slot(1'b1, 24'h654321, 32);
    check("g2b_vld_cnt", vld_cnt, v0 + 3);
    check("g2b_left",  {8'h0, bus.o_left},  32'h0F0F0F);
    check("g2b_right", {8'h0, bus.o_right}, 32'h654321);
    check("g2_err_cnt", err_cnt, e0);

    // Short (16-bit) left slot between good frames.
    v0 = vld_cnt; e0 = err_cnt;
    send_slot(1'b0, 24'h111111, 16);
    send_slot(1'b1, 24'h222222, 32);
    check("g3_err_once", err_cnt, e0 + 1);
    check("g3_no_vld",   vld_cnt, v0);
    check("g3_hold_left", {8'h0, bus.o_left}, 32'h0F0F0F);
    send_frame(24'h333333, 24'h444444, 32);
    check("g3_vld_after", vld_cnt, v0 + 1);
    check("g3_left",  {8'h0, bus.o_left},  32'h333333);
    check("g3_right", {8'h0, bus.o_right}, 32'h444444);
    check("g3_err_after", err_cnt, e0 + 1);

    // Reset asserted while the right word is shifting.
    send_slot(1'b0, 24'h555555, 32);
    v0 = vld_cnt; e0 = err_cnt;
    fork
      send_slot(1'b1, 24'h666666, 32);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("g4_rst_left",  {8'h0, bus.o_left},  32'h0);
        check("g4_rst_right", {8'h0, bus.o_right}, 32'h0);
        check("g4_rst_valid", {31'h0, bus.o_valid}, 32'h0);
        repeat (40) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check("g4_no_spurious_vld", vld_cnt, v0);
    send_frame(24'h777777, 24'h888888, 32);
    check("g4_vld_cnt", vld_cnt, v0 + 1);
    check("g4_left",  {8'h0, bus.o_left},  32'h777777);
    check("g4_right", {8'h0, bus.o_right}, 32'h888888);
    check("g4_err_cnt", err_cnt, e0);

    // Reset released mid-left word; that partial frame must not produce a pair.
    rst_n = 1'b0;
    v0 = vld_cnt; e0 = err_cnt;
    fork
      send_frame(24'h999999, 24'h9A9A9A, 32);
      begin
        repeat (80) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check("g5_partial_no_vld", vld_cnt, v0);
    send_frame(24'hAAAAAA, 24'hBBBBBB, 32);
    check("g5_first_left",  {8'h0, bus.o_left},  32'hAAAAAA);
    check("g5_first_right", {8'h0, bus.o_right}, 32'hBBBBBB);
    send_frame(24'hCCCCCC, 24'hDDDDDD, 32);
    check("g5_vld_cnt", vld_cnt, v0 + 2);
    check("g5_left",  {8'h0, bus.o_left},  32'hCCCCCC);
    check("g5_right", {8'h0, bus.o_right}, 32'hDDDDDD);
    check("g5_err_cnt", err_cnt, e0);

    // Stream starts on a right slot after reset.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    v0 = vld_cnt; e0 = err_cnt;
    send_slot(1'b1, 24'h121212, 32);
    check("g6_right_first_no_vld", vld_cnt, v0);
    check("g6_right_first_no_err", err_cnt, e0);
    send_frame(24'h343434, 24'h565656, 32);
    check("g6_vld_cnt", vld_cnt, v0 + 1);
    check("g6_left",  {8'h0, bus.o_left},  32'h343434);
    check("g6_right", {8'h0, bus.o_right}, 32'h565656);
    check("g6_latency", lat, EXP_LAT);

    repeat (10) @(negedge clk);
    check("strobe_width", pw_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
